nios2e_lcd_16207_seq: RTL and testbench
=======================================

Name: nios2e_lcd_16207_seq

Overview:
- Timing sequencer placed between the Avalon-MM bus and an HD44780-compatible 16x2 LCD (16207 header).
- Replaces the direct pin mapping, in which LCD_E simply follows read|write, with correct HD44780 bus cycles: RS/RW setup, an enable pulse of at least minimum width, and hold.
- Stalls the master with waitrequest until each cycle completes.
- Optionally polls the busy flag after every write so software never has to.

Parameters:
- SETUP_CYC, 3: clk cycles that RS/RW/data are stable before LCD_E rises (tAS). Range 1..255.
- E_HIGH_CYC, 12: clk cycles LCD_E is high (PWEH, 240 ns at 50 MHz). Range 1..255.
- HOLD_CYC, 2: clk cycles RS/RW/data are held after LCD_E falls (tAH/tH). Range 1..255.
- POLL_BUSY, 1: 1 = poll the busy flag after each write before acking; 0 = ack immediately after HOLD.
- POLL_MAX, 4095: maximum busy-flag polls per write before the block gives up.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- address, in, 2: bit1 = RS, bit0 = read select. 0 = cmd write, 1 = status read, 2 = data write, 3 = data read.
- read, in, 1: Avalon read.
- write, in, 1: Avalon write.
- writedata, in, 8: Avalon write data.
- readdata, out, 8: Avalon read data; valid in the ack cycle.
- waitrequest, out, 1: Avalon stall.
- busy_timeout, out, 1: sticky flag, set when POLL_MAX is exhausted.
- LCD_E, out, 1: LCD enable.
- LCD_RS, out, 1: LCD register select.
- LCD_RW, out, 1: LCD read/not-write.
- LCD_data, inout, 8: LCD data bus.

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE; LCD_E = 0, LCD_RS = 0, LCD_RW = 1, LCD_data = Z.
  - readdata = 0, busy_timeout = 0.
  - An LCD_E pulse in progress is truncated immediately.
- waitrequest = (read|write) & ~ack, where ack is a registered one-cycle pulse. It is 0 when no request is present.
- Request decode in IDLE:
  - write has priority if read and write are both high.
  - Write to an odd address, or read from an even address: illegal. Ack the next cycle, drive no LCD cycle, readdata = 0x00.
- States: IDLE -> SETUP -> PULSE -> HOLD -> (POLL_SETUP -> POLL_PULSE -> POLL_HOLD)* -> ACK -> IDLE.
- On leaving IDLE: latch RS = address[1], RW = read, data = writedata.
  - Outputs are registered, so pins change on the IDLE->SETUP edge.
  - Bus inputs are ignored until ACK.
- SETUP: lasts SETUP_CYC cycles, LCD_E = 0. LCD_data is driven with the latched data only when RW = 0; otherwise Z.
- PULSE: lasts E_HIGH_CYC cycles, LCD_E = 1. For reads, LCD_data is sampled on the last PULSE cycle into readdata.
- HOLD: lasts HOLD_CYC cycles, LCD_E = 0, RS/RW/data unchanged.
- After HOLD:
  - Read, or write with POLL_BUSY = 0: go to ACK.
  - Write with POLL_BUSY = 1: go to POLL_SETUP with RS = 0, RW = 1, LCD_data = Z. The poll cycle uses the same three phase lengths.
- After POLL_HOLD:
  - If the sampled bit7 = 0: go to ACK.
  - Else increment the poll counter (width clog2(POLL_MAX+1)). If counter == POLL_MAX, set busy_timeout and go to ACK; else repeat the poll.
  - The counter clears on each new transaction.
- ACK: exactly one cycle, ack = 1, LCD pins idle (E = 0, RW = 1, data Z), then IDLE.
- Latency:
  - Host write with the busy flag already clear: waitrequest is high for 1 + 2×(S+E+H) cycles, then low for 1 cycle.
  - Read: high for 1 + S + E + H cycles.
- Phase counter: 8-bit, loads phase length − 1 and counts down. Terminal count 0 advances state with no idle gap between phases.
- The master dropping read/write mid-cycle (Avalon violation): the LCD cycle still completes and the ack is discarded.
- busy_timeout clears only on reset.

Decomposition:
- Package nios2e_lcd_16207_pkg holds:
  - state enumeration;
  - address constants ADDR_CMD_WR = 0, ADDR_STAT_RD = 1, ADDR_DATA_WR = 2, ADDR_DATA_RD = 3;
  - BF_BIT = 7.
- One natural sub-module, nios2e_lcd_16207_bus_cycle.
  - Inputs: start, rs, rw, wdata.
  - Outputs: the LCD pins, rdata, done.
  - Runs one SETUP/PULSE/HOLD cycle and is instantiated once, shared by host and poll cycles.
  - The top level holds the transaction FSM, the poll counter and the Avalon logic.

Test Plan:
- Cmd write, defaults, POLL_BUSY = 0, write 0x38 to address 0 → RS = 0, RW = 0, data = 0x38 for 3 cycles before E; E high for 12 cycles; held for 2 cycles; waitrequest high 18 cycles, then low 1 cycle.
- Status read from address 1, LCD model drives 0x8A → readdata = 0x8A in the ack cycle; LCD_data Z throughout; waitrequest high 18 cycles.
- Data write 0x41 to address 2, POLL_BUSY = 1, model busy for 3 polls → 4 poll cycles observed; ack after 1 + 5×17 = 86 waitrequest-high cycles; busy_timeout = 0.
- Busy stuck at 1, POLL_MAX = 4 → exactly 4 extra polls; ack asserted; busy_timeout = 1 and remains set across the next transaction.
- Write to address 1 / read from address 0 → no LCD_E activity; ack after 1 cycle; readdata = 0x00.
- reset_n asserted during PULSE → LCD_E = 0 and LCD_data Z in the same timestep; after release, a new write sequences normally.

Source files
------------

// File: rtl/nios2e_lcd_16207_pkg.sv
// Shared types and constants for the HD44780 (16207) bus-cycle sequencer.
package nios2e_lcd_16207_pkg;

  // The host/poll cycles share one SETUP/PULSE/HOLD engine, so the transaction
  // FSM only tracks which cycle is running; the phase FSM lives in the engine.
  typedef enum logic [1:0] {
    TXN_IDLE,
    TXN_HOST,
    TXN_POLL,
    TXN_ACK
  } txn_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } phase_e;

  localparam logic [1:0] ADDR_CMD_WR  = 2'd0;
  localparam logic [1:0] ADDR_STAT_RD = 2'd1;
  localparam logic [1:0] ADDR_DATA_WR = 2'd2;
  localparam logic [1:0] ADDR_DATA_RD = 2'd3;

  localparam int unsigned BF_BIT = 7;

endpackage

// File: rtl/nios2e_lcd_16207_bus_cycle.sv
// One HD44780 bus cycle: RS/RW/data setup, enable pulse, hold. A start on the
// last HOLD cycle chains the next cycle with no idle gap.
module nios2e_lcd_16207_bus_cycle
  import nios2e_lcd_16207_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 3,
  parameter int unsigned E_HIGH_CYC = 12,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] lcd_data_i,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe_o,
  output logic [7:0] rdata_o,
  output logic       done_o
);

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] E_LD     = 8'(E_HIGH_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  phase_e     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       e_q, e_d;
  logic       rs_q, rs_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rdata_q, rdata_d;
  logic       last;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    last    = (cnt_q == '0);
    done_o  = (phase_q == PH_HOLD) && last;

    if ((phase_q == PH_IDLE || done_o) && start_i) begin
      phase_d = PH_SETUP;
      cnt_d   = SETUP_LD;
      e_d     = 1'b0;
      rs_d    = rs_i;
      rw_d    = rw_i;
      oe_d    = ~rw_i;
      data_d  = wdata_i;
    end else begin
      unique case (phase_q)
        PH_SETUP: begin
          if (last) begin
            phase_d = PH_PULSE;
            cnt_d   = E_LD;
            e_d     = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        PH_PULSE: begin
          if (last) begin
            phase_d = PH_HOLD;
            cnt_d   = HOLD_LD;
            e_d     = 1'b0;
            // Read data is captured while E is still high.
            if (rw_q) rdata_d = lcd_data_i;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        PH_HOLD: begin
          if (last) begin
            phase_d = PH_IDLE;
            rs_d    = 1'b0;
            rw_d    = 1'b1;
            oe_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      oe_q    <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  assign lcd_e_o       = e_q;
  assign lcd_rs_o      = rs_q;
  assign lcd_rw_o      = rw_q;
  assign lcd_data_o    = data_q;
  assign lcd_data_oe_o = oe_q;
  assign rdata_o       = rdata_q;

endmodule

// File: rtl/nios2e_lcd_16207_seq.sv
// Avalon-MM slave that turns bus accesses into timed HD44780 cycles, stalling
// the master and optionally polling the busy flag after each write.
module nios2e_lcd_16207_seq
  import nios2e_lcd_16207_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 3,
  parameter int unsigned E_HIGH_CYC = 12,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned POLL_BUSY  = 1,
  parameter int unsigned POLL_MAX   = 4095
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       busy_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int unsigned   PW         = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

  txn_state_e    state_q, state_d;
  logic [PW-1:0] poll_q, poll_d, poll_inc;
  logic [7:0]    readdata_q, readdata_d;
  logic          bto_q, bto_d;
  logic          is_rd_q, is_rd_d;

  logic          start, cyc_rs, cyc_rw, cyc_done;
  logic [7:0]    cyc_wdata, cyc_rdata;
  logic [7:0]    lcd_dout;
  logic          lcd_oe;
  logic          legal;

  // Write wins when both strobes are high.
  assign legal = write ? (address[0] == 1'b0) : (address[0] == 1'b1);

  always_comb begin
    state_d    = state_q;
    poll_d     = poll_q;
    readdata_d = readdata_q;
    bto_d      = bto_q;
    is_rd_d    = is_rd_q;
    start      = 1'b0;
    cyc_rs     = address[1];
    cyc_rw     = ~write;
    cyc_wdata  = writedata;
    poll_inc   = poll_q + 1'b1;

    unique case (state_q)
      TXN_IDLE: begin
        if (read || write) begin
          readdata_d = '0;
          poll_d     = '0;
          is_rd_d    = ~write;
          if (legal) begin
            start   = 1'b1;
            state_d = TXN_HOST;
          end else begin
            state_d = TXN_ACK;
          end
        end
      end
      TXN_HOST: begin
        if (cyc_done) begin
          if (is_rd_q) begin
            readdata_d = cyc_rdata;
            state_d    = TXN_ACK;
          end else if (POLL_BUSY != 0) begin
            start     = 1'b1;
            cyc_rs    = 1'b0;
            cyc_rw    = 1'b1;
            cyc_wdata = '0;
            state_d   = TXN_POLL;
          end else begin
            state_d = TXN_ACK;
          end
        end
      end
      TXN_POLL: begin
        if (cyc_done) begin
          if (!cyc_rdata[BF_BIT]) begin
            state_d = TXN_ACK;
          end else begin
            poll_d = poll_inc;
            if (poll_inc == POLL_LIMIT) begin
              bto_d   = 1'b1;
              state_d = TXN_ACK;
            end else begin
              start     = 1'b1;
              cyc_rs    = 1'b0;
              cyc_rw    = 1'b1;
              cyc_wdata = '0;
            end
          end
        end
      end
      TXN_ACK: state_d = TXN_IDLE;
      default: state_d = TXN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= TXN_IDLE;
      poll_q     <= '0;
      readdata_q <= '0;
      bto_q      <= 1'b0;
      is_rd_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      readdata_q <= readdata_d;
      bto_q      <= bto_d;
      is_rd_q    <= is_rd_d;
    end
  end

  nios2e_lcd_16207_bus_cycle #(
    .SETUP_CYC  (SETUP_CYC),
    .E_HIGH_CYC (E_HIGH_CYC),
    .HOLD_CYC   (HOLD_CYC)
  ) u_bus_cycle (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (start),
    .rs_i          (cyc_rs),
    .rw_i          (cyc_rw),
    .wdata_i       (cyc_wdata),
    .lcd_data_i    (LCD_data),
    .lcd_e_o       (LCD_E),
    .lcd_rs_o      (LCD_RS),
    .lcd_rw_o      (LCD_RW),
    .lcd_data_o    (lcd_dout),
    .lcd_data_oe_o (lcd_oe),
    .rdata_o       (cyc_rdata),
    .done_o        (cyc_done)
  );

  assign LCD_data     = lcd_oe ? lcd_dout : 8'hzz;
  assign waitrequest  = (read | write) & (state_q != TXN_ACK);
  assign readdata     = readdata_q;
  assign busy_timeout = bto_q;

endmodule

// File: tb/tb_nios2e_lcd_16207_seq.sv
// Bench for nios2e_lcd_16207_seq: one non-polling and one polling instance,
// each with a small HD44780 model; expected per-cycle traces built from phase rules.
module tb_nios2e_lcd_16207_seq;

  localparam int unsigned S    = 3;
  localparam int unsigned EH   = 12;
  localparam int unsigned H    = 2;
  localparam int unsigned PMAX = 4;
  localparam int unsigned CYC  = S + EH + H;

  typedef struct packed {
    logic       wr;
    logic       e;
    logic       rs_care;
    logic       rs;
    logic       rw;
    logic       d_care;
    logic [7:0] d;
    logic       rd_care;
    logic [7:0] rd;
    logic       set_bto;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] np_addr, p_addr;
  logic       np_rd, np_wr, p_rd, p_wr;
  logic [7:0] np_wd, p_wd, np_rdata, p_rdata;
  logic       np_wait, np_bto, np_e, np_rs, np_rw;
  logic       p_wait, p_bto, p_e, p_rs, p_rw;
  tri1  [7:0] np_lcd;
  tri1  [7:0] p_lcd;

  nios2e_lcd_16207_seq #(
    .SETUP_CYC (S), .E_HIGH_CYC (EH), .HOLD_CYC (H), .POLL_BUSY (0), .POLL_MAX (4095)
  ) u_nopoll (
    .clk (clk), .reset_n (reset_n), .address (np_addr), .read (np_rd), .write (np_wr),
    .writedata (np_wd), .readdata (np_rdata), .waitrequest (np_wait),
    .busy_timeout (np_bto), .LCD_E (np_e), .LCD_RS (np_rs), .LCD_RW (np_rw),
    .LCD_data (np_lcd)
  );

  nios2e_lcd_16207_seq #(
    .SETUP_CYC (S), .E_HIGH_CYC (EH), .HOLD_CYC (H), .POLL_BUSY (1), .POLL_MAX (PMAX)
  ) u_poll (
    .clk (clk), .reset_n (reset_n), .address (p_addr), .read (p_rd), .write (p_wr),
    .writedata (p_wd), .readdata (p_rdata), .waitrequest (p_wait),
    .busy_timeout (p_bto), .LCD_E (p_e), .LCD_RS (p_rs), .LCD_RW (p_rw),
    .LCD_data (p_lcd)
  );

  // LCD model: busy for the first busy_n status reads of a transaction, or forever when stuck.
  logic        stuck;
  logic [7:0]  data_val;
  int unsigned busy_n, poll_base;
  int unsigned poll_seen = 0;
  logic        bf;
  assign bf     = stuck || ((poll_seen - poll_base) < busy_n);
  assign np_lcd = (np_e && np_rw) ? (np_rs ? data_val : {bf, 7'h0A}) : 8'hzz;
  assign p_lcd  = (p_e && p_rw) ? (p_rs ? data_val : {bf, 7'h0A}) : 8'hzz;
  always @(negedge p_e) if (p_rw && !p_rs) poll_seen++;

  logic       sel;
  logic       o_wait, o_e, o_rs, o_rw, o_bto;
  logic [7:0] o_d, o_rdata;
  always_comb begin
    if (sel) begin
      o_wait = p_wait; o_e = p_e; o_rs = p_rs; o_rw = p_rw; o_bto = p_bto; o_d = p_lcd; o_rdata = p_rdata;
    end else begin
      o_wait = np_wait; o_e = np_e; o_rs = np_rs; o_rw = np_rw; o_bto = np_bto; o_d = np_lcd; o_rdata = np_rdata;
    end
  end

  int unsigned e_rises = 0;
  always @(posedge o_e) e_rises++;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  exp_t        q[$];
  logic        chk_en = 1'b0;
  logic        exp_bto [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic wr, input logic e, input logic rsc, input logic rs,
                              input logic rw, input logic dc, input logic [7:0] d,
                              input logic rdc, input logic [7:0] rd, input logic sb);
    exp_t x;
    x = '{wr, e, rsc, rs, rw, dc, d, rdc, rd, sb};
    return x;
  endfunction

  task automatic model_cycle(input logic rs, input logic rw, input logic drv, input logic [7:0] wd);
    logic e;
    for (int k = 0; k < int'(CYC); k++) begin
      e = (k >= int'(S)) && (k < int'(S + EH));
      q.push_back(mk(1'b1, e, 1'b1, rs, rw, !(e && rw), drv ? wd : 8'hFF, 1'b0, 8'h00, 1'b0));
    end
  endtask

  task automatic model_txn(input logic s, input logic wr, input logic [1:0] a, input logic [7:0] wd,
                           input int unsigned nbusy, input logic stk, input logic [7:0] exp_rd);
    logic        legal, to;
    int unsigned np;
    legal = wr ? !a[0] : a[0];
    to = 1'b0;
    np = 0;
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0));
    if (legal) begin
      model_cycle(a[1], !wr, wr, wd);
      if (wr && s) begin
        if (stk || nbusy >= PMAX) begin np = PMAX; to = 1'b1; end
        else np = nbusy + 1;
        for (int k = 0; k < int'(np); k++) model_cycle(1'b0, 1'b1, 1'b0, 8'h00);
      end
    end
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF,
                   !wr || !legal, legal ? exp_rd : 8'h00, to));
  endtask

  task automatic set_bus(input logic s, input logic rd, input logic wr, input logic [1:0] a, input logic [7:0] wd);
    if (s) begin p_rd = rd; p_wr = wr; p_addr = a; p_wd = wd; end
    else begin np_rd = rd; np_wr = wr; np_addr = a; np_wd = wd; end
  endtask

  task automatic txn(input string name, input logic s, input logic rd, input logic wr,
                     input logic [1:0] a, input logic [7:0] wd, input int unsigned nbusy,
                     input logic stk, input logic [7:0] exp_rd,
                     input int unsigned exp_lat, input int unsigned exp_pulses);
    int unsigned lat, e0;
    logic        got;
    @(posedge clk); #2;
    sel = s; busy_n = nbusy; stuck = stk; poll_base = poll_seen;
    model_txn(s, wr, a, wd, nbusy, stk, exp_rd);
    set_bus(s, rd, wr, a, wd);
    e0 = e_rises; lat = 0; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_wait) lat++;
      else begin got = 1'b1; break; end
    end
    check({name, "/ack_seen"}, 32'(got), 32'd1);
    check({name, "/wait_cycles"}, lat, exp_lat);
    @(posedge clk); #2;
    set_bus(s, 1'b0, 1'b0, 2'd0, 8'h00);
    check({name, "/e_pulses"}, e_rises - e0, exp_pulses);
  endtask

  initial begin : cmp
    exp_t x;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (q.size() != 0) x = q.pop_front();
        else x = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
        if (x.set_bto) exp_bto[sel] = 1'b1;
        check("pins{wait,E,RS,RW,data}",
              32'({o_wait, o_e, x.rs_care & o_rs, o_rw, x.d_care ? o_d : 8'h00}),
              32'({x.wr, x.e, x.rs_care & x.rs, x.rw, x.d_care ? x.d : 8'h00}));
        check("busy_timeout", 32'(o_bto), 32'(exp_bto[sel]));
        if (x.rd_care) check("readdata", 32'(o_rdata), 32'(x.rd));
      end
    end
  end

  initial begin : main
    logic got;
    sel = 1'b1; stuck = 1'b0; busy_n = 0; poll_base = 0; data_val = 8'h5C;
    exp_bto[0] = 1'b0; exp_bto[1] = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    set_bus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rst/E", 32'(p_e), 32'd0);
    check("rst/RS", 32'(p_rs), 32'd0);
    check("rst/RW", 32'(p_rw), 32'd1);
    check("rst/data_z", 32'(p_lcd), 32'hFF);
    check("rst/readdata", 32'(p_rdata), 32'd0);
    check("rst/busy_timeout", 32'(p_bto), 32'd0);
    check("rst/waitrequest", 32'(p_wait), 32'd0);
    check("rst/np_E", 32'(np_e), 32'd0);
    chk_en = 1'b1;

    txn("cmd_wr",   1'b0, 1'b0, 1'b1, 2'd0, 8'h38, 0, 1'b0, 8'h00, 18, 1);
    txn("stat_rd",  1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 0, 1'b1, 8'h8A, 18, 1);
    txn("data_rd",  1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 0, 1'b0, 8'h5C, 18, 1);
    txn("ill_rd",   1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 0, 1'b0, 8'h00, 1, 0);
    txn("ill_wr",   1'b0, 1'b0, 1'b1, 2'd1, 8'hA5, 0, 1'b0, 8'h00, 1, 0);
    txn("rw_both",  1'b0, 1'b1, 1'b1, 2'd2, 8'h5A, 0, 1'b0, 8'h00, 18, 1);

    txn("poll3",    1'b1, 1'b0, 1'b1, 2'd2, 8'h41, 3, 1'b0, 8'h00, 86, 5);
    check("poll3/bto", 32'(p_bto), 32'd0);
    txn("poll0",    1'b1, 1'b0, 1'b1, 2'd0, 8'h01, 0, 1'b0, 8'h00, 35, 2);
    txn("p_rd",     1'b1, 1'b1, 1'b0, 2'd3, 8'h00, 0, 1'b0, 8'h5C, 18, 1);
    txn("stuck",    1'b1, 1'b0, 1'b1, 2'd0, 8'h02, 0, 1'b1, 8'h00, 86, 5);
    check("stuck/bto", 32'(p_bto), 32'd1);
    txn("after_to", 1'b1, 1'b0, 1'b1, 2'd2, 8'h42, 0, 1'b0, 8'h00, 35, 2);
    check("sticky_bto", 32'(p_bto), 32'd1);

    // Reset asserted in the middle of the enable pulse.
    @(posedge clk); #2;
    sel = 1'b1; busy_n = 0; stuck = 1'b0; poll_base = poll_seen;
    model_txn(1'b1, 1'b1, 2'd0, 8'h77, 0, 1'b0, 8'h00);
    set_bus(1'b1, 1'b0, 1'b1, 2'd0, 8'h77);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_e) begin got = 1'b1; break; end
    end
    check("rst_mid/e_reached", 32'(got), 32'd1);
    repeat (4) @(negedge clk);
    #2;
    chk_en = 1'b0;
    q.delete();
    reset_n = 1'b0;
    #1;
    check("rst_mid/E", 32'(p_e), 32'd0);
    check("rst_mid/data_z", 32'(p_lcd), 32'hFF);
    check("rst_mid/RW", 32'(p_rw), 32'd1);
    check("rst_mid/bto_clr", 32'(p_bto), 32'd0);
    set_bus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    exp_bto[0] = 1'b0; exp_bto[1] = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    txn("post_rst", 1'b1, 1'b0, 1'b1, 2'd2, 8'h43, 0, 1'b0, 8'h00, 35, 2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
